// File: rtl/proc_ctrl.sv
// rtl/proc_ctrl.sv - T0..T3 instruction sequencer for a small register-file datapath
module proc_ctrl #(
    parameter logic [8:0] IR_RESET = 9'h000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       run,
    input  logic [8:0] din,
    output logic       irin,
    output logic [7:0] rin,
    output logic [7:0] rout,
    output logic       dinout,
    output logic       gout,
    output logic       ain,
    output logic       gin,
    output logic       sub,
    output logic       done,
    output logic       illegal
);

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    state_t     state;
    logic [8:0] ir;

    logic [2:0] opcode;
    logic [2:0] rx;
    logic [2:0] ry;
    logic       is_alu;
    logic       is_undef;

    assign opcode   = ir[8:6];
    assign rx       = ir[5:3];
    assign ry       = ir[2:0];
    assign is_alu   = (opcode == OP_ADD) || (opcode == OP_SUB);
    assign is_undef = opcode[2];

    // One-hot register select for a 3-bit register index.
    function automatic logic [7:0] reg_sel(input logic [2:0] idx);
        logic [7:0] v;
        v = 8'h00;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Sequencer state and instruction register; IR only loads on a T0 start.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= T0;
            ir    <= IR_RESET;
        end else begin
            case (state)
                T0: begin
                    if (run) begin
                        ir    <= din;
                        state <= T1;
                    end
                end
                T1: begin
                    if (is_alu) begin
                        state <= T2;
                    end else begin
                        state <= T0;
                    end
                end
                T2: begin
                    // A non-ALU IR here can only come from corruption; recover to T0.
                    if (is_alu) begin
                        state <= T3;
                    end else begin
                        state <= T0;
                    end
                end
                T3: begin
                    state <= T0;
                end
                default: begin
                    state <= T0;
                end
            endcase
        end
    end

    // Control strobes decoded from state and IR, forced quiet while reset is high.
    always_comb begin
        irin    = 1'b0;
        rin     = 8'h00;
        rout    = 8'h00;
        dinout  = 1'b0;
        gout    = 1'b0;
        ain     = 1'b0;
        gin     = 1'b0;
        sub     = 1'b0;
        done    = 1'b0;
        illegal = 1'b0;
        if (!reset) begin
            case (state)
                T0: begin
                    irin = run;
                end
                T1: begin
                    if (is_undef) begin
                        done    = 1'b1;
                        illegal = 1'b1;
                    end else begin
                        case (opcode)
                            OP_MV: begin
                                rout = reg_sel(ry);
                                rin  = reg_sel(rx);
                                done = 1'b1;
                            end
                            OP_MVI: begin
                                dinout = 1'b1;
                                rin    = reg_sel(rx);
                                done   = 1'b1;
                            end
                            default: begin
                                rout = reg_sel(rx);
                                ain  = 1'b1;
                                sub  = (opcode == OP_SUB);
                            end
                        endcase
                    end
                end
                T2: begin
                    if (is_alu) begin
                        rout = reg_sel(ry);
                        gin  = 1'b1;
                        sub  = (opcode == OP_SUB);
                    end
                end
                T3: begin
                    if (is_alu) begin
                        gout = 1'b1;
                        rin  = reg_sel(rx);
                        done = 1'b1;
                    end
                end
                default: begin
                    irin = 1'b0;
                end
            endcase
        end
    end

endmodule
